// File: rtl/sonar_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sonar_pkg : state codes, frame ASCII constants and BCD helper        |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package sonar_pkg;

   localparam logic [3:0] c_st_inicial        = 4'h0;
   localparam logic [3:0] c_st_prepara        = 4'h1;
   localparam logic [3:0] c_st_gera_trigger   = 4'h2;
   localparam logic [3:0] c_st_espera_echo    = 4'h3;
   localparam logic [3:0] c_st_mede           = 4'h4;
   localparam logic [3:0] c_st_armazena       = 4'h5;
   localparam logic [3:0] c_st_transmite      = 4'h6;
   localparam logic [3:0] c_st_prox_canal     = 4'h7;
   localparam logic [3:0] c_st_espera_periodo = 4'h8;
   localparam logic [3:0] c_st_fim            = 4'hF;

   localparam logic [7:0] c_ascii_virgula    = 8'h2C;
   localparam logic [7:0] c_ascii_cerquilha  = 8'h23;
   localparam logic [7:0] c_ascii_exclamacao = 8'h21;
   localparam logic [7:0] c_ascii_zero       = 8'h30;

   localparam int c_bytes_quadro = 6;

   function automatic logic [11:0] para_bcd(input int unsigned valor);
      para_bcd = {4'((valor / 100) % 10), 4'((valor / 10) % 10), 4'(valor % 10)};
   endfunction

endpackage
`default_nettype wire

// File: rtl/contador_cm_bcd.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | contador_cm_bcd : per-centimetre prescaler + saturating 3-digit BCD  |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module contador_cm_bcd #(
   parameter int TICKS_CM = 2941
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_limpa,
   input  logic        i_habilita,
   input  logic [11:0] i_limite,
   output logic [11:0] o_bcd,
   output logic        o_saturado
);
   localparam int c_w_pre = (TICKS_CM > 1) ? $clog2(TICKS_CM) : 1;

   logic [c_w_pre-1:0] r_pre;
   logic [11:0]        r_bcd;
   logic [11:0]        w_bcd_inc;
   logic               w_tick;

   assign o_bcd      = r_bcd;
   assign o_saturado = (r_bcd == i_limite);
   assign w_tick     = (r_pre == c_w_pre'(TICKS_CM - 1));

   always_comb begin
      w_bcd_inc = r_bcd;
      if (r_bcd[3:0] != 4'd9) begin
         w_bcd_inc[3:0] = r_bcd[3:0] + 4'd1;
      end else begin
         w_bcd_inc[3:0] = 4'd0;
         if (r_bcd[7:4] != 4'd9) begin
            w_bcd_inc[7:4] = r_bcd[7:4] + 4'd1;
         end else begin
            w_bcd_inc[7:4]  = 4'd0;
            w_bcd_inc[11:8] = (r_bcd[11:8] == 4'd9) ? 4'd0 : r_bcd[11:8] + 4'd1;
         end
      end
   end

   // Prescaler freezes once the limit is reached so the result stays put.
   always_ff @(posedge clk) begin
      if (!rst_n || i_limpa) begin
         r_pre <= '0;
         r_bcd <= '0;
      end else if (i_habilita && !o_saturado) begin
         if (w_tick) begin
            r_pre <= '0;
            r_bcd <= w_bcd_inc;
         end else begin
            r_pre <= r_pre + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/sonar_multicanal.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sonar_multicanal : multi-channel ultrasonic ranger with ASCII frames |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
module sonar_multicanal
   import sonar_pkg::*;
#(
   parameter int N_CANAIS      = 4,
   parameter int TICKS_TRIGGER = 500,
   parameter int TICKS_CM      = 2941,
   parameter int MAX_CM        = 400,
   parameter int ESPERA_MAX    = 1500000,
   parameter int TICKS_PERIODO = 50000000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                medir,
   input  logic                modo,
   input  logic                parar,
   input  logic [N_CANAIS-1:0] echo,
   output logic [N_CANAIS-1:0] trigger,
   output logic [7:0]          tx_dado,
   output logic                tx_valido,
   input  logic                tx_pronto,
   output logic [11:0]         medida,
   output logic [2:0]          canal,
   output logic                medida_valida,
   output logic                timeout,
   output logic                pronto,
   output logic [3:0]          db_estado
);
   localparam int c_max_cnt = (ESPERA_MAX > TICKS_TRIGGER) ? ESPERA_MAX : TICKS_TRIGGER;
   localparam int c_w_cnt   = $clog2(c_max_cnt + 1);
   localparam int c_w_per   = $clog2(TICKS_PERIODO + 1);

   logic [3:0]          r_estado;
   logic [3:0]          w_prox;
   logic [2:0]          r_idx;
   logic [2:0]          r_byte;
   logic [c_w_cnt-1:0]  r_cnt;
   logic [c_w_per-1:0]  r_periodo;
   logic [N_CANAIS-1:0] r_echo_s1;
   logic [N_CANAIS-1:0] r_echo_s2;
   logic [N_CANAIS-1:0] r_echo_s3;
   logic [11:0]         r_medida;
   logic [2:0]          r_canal;
   logic                r_timeout;

   logic        w_eco;
   logic        w_eco_ant;
   logic        w_subida;
   logic        w_ultimo;
   logic        w_habilita;
   logic        w_sat;
   logic [11:0] w_bcd;

   always_comb begin
      w_eco     = 1'b0;
      w_eco_ant = 1'b0;
      for (int i = 0; i < N_CANAIS; i++) begin
         if (r_idx == 3'(i)) begin
            w_eco     = r_echo_s2[i];
            w_eco_ant = r_echo_s3[i];
         end
      end
   end

   assign w_subida   = w_eco && !w_eco_ant;
   assign w_ultimo   = (r_idx == 3'(N_CANAIS - 1));
   // The rise cycle itself already counts as echo-high time.
   assign w_habilita = ((r_estado == c_st_espera_echo) && w_subida) ||
                       ((r_estado == c_st_mede) && w_eco);

   contador_cm_bcd #(
      .TICKS_CM (TICKS_CM)
   ) u_contador (
      .clk        (clock),
      .rst_n      (reset),
      .i_limpa    (r_estado == c_st_gera_trigger),
      .i_habilita (w_habilita),
      .i_limite   (para_bcd(MAX_CM)),
      .o_bcd      (w_bcd),
      .o_saturado (w_sat)
   );

   always_ff @(posedge clock) begin
      if (!reset) r_estado <= c_st_inicial;
      else        r_estado <= w_prox;
   end

   always_comb begin
      w_prox = r_estado;
      case (r_estado)
         c_st_inicial:      if (medir) w_prox = c_st_prepara;
         c_st_prepara:      w_prox = c_st_gera_trigger;
         c_st_gera_trigger: if (r_cnt == c_w_cnt'(TICKS_TRIGGER - 1)) w_prox = c_st_espera_echo;
         c_st_espera_echo: begin
            if (w_subida)                                 w_prox = c_st_mede;
            else if (r_cnt == c_w_cnt'(ESPERA_MAX - 1))   w_prox = c_st_armazena;
         end
         c_st_mede:         if (w_sat || !w_eco) w_prox = c_st_armazena;
         c_st_armazena:     w_prox = c_st_transmite;
         c_st_transmite: begin
            if (tx_pronto && (r_byte == 3'(c_bytes_quadro - 1))) w_prox = c_st_prox_canal;
         end
         c_st_prox_canal: begin
            if (w_ultimo)   w_prox = (parar || !modo) ? c_st_fim : c_st_espera_periodo;
            else if (parar) w_prox = c_st_fim;
            else            w_prox = c_st_gera_trigger;
         end
         c_st_espera_periodo: begin
            if (parar)                                            w_prox = c_st_fim;
            else if (r_periodo >= c_w_per'(TICKS_PERIODO - 1))    w_prox = c_st_prepara;
         end
         c_st_fim:          w_prox = c_st_inicial;
         default:           w_prox = c_st_inicial;
      endcase
   end

   always_comb begin
      trigger       = '0;
      tx_valido     = 1'b0;
      tx_dado       = 8'h00;
      medida_valida = 1'b0;
      pronto        = 1'b0;
      case (r_estado)
         c_st_gera_trigger: begin
            for (int i = 0; i < N_CANAIS; i++) trigger[i] = (r_idx == 3'(i));
         end
         c_st_armazena:     medida_valida = 1'b1;
         c_st_transmite: begin
            tx_valido = 1'b1;
            case (r_byte)
               3'd0:    tx_dado = c_ascii_zero + {5'b0, r_canal};
               3'd1:    tx_dado = c_ascii_virgula;
               3'd2:    tx_dado = c_ascii_zero + {4'b0, r_medida[11:8]};
               3'd3:    tx_dado = c_ascii_zero + {4'b0, r_medida[7:4]};
               3'd4:    tx_dado = c_ascii_zero + {4'b0, r_medida[3:0]};
               default: tx_dado = r_timeout ? c_ascii_exclamacao : c_ascii_cerquilha;
            endcase
         end
         c_st_prox_canal:   pronto = w_ultimo;
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_idx     <= '0;
         r_byte    <= '0;
         r_cnt     <= '0;
         r_periodo <= '0;
         r_echo_s1 <= '0;
         r_echo_s2 <= '0;
         r_echo_s3 <= '0;
         r_medida  <= '0;
         r_canal   <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_echo_s1 <= echo;
         r_echo_s2 <= r_echo_s1;
         r_echo_s3 <= r_echo_s2;
         r_cnt     <= (w_prox != r_estado) ? '0 : r_cnt + 1'b1;

         if (w_prox == c_st_prepara)
            r_periodo <= '0;
         else if (r_periodo != c_w_per'(TICKS_PERIODO))
            r_periodo <= r_periodo + 1'b1;

         if (r_estado == c_st_prepara)
            r_idx <= '0;
         else if ((r_estado == c_st_prox_canal) && !w_ultimo && !parar)
            r_idx <= r_idx + 3'd1;

         if (r_estado != c_st_transmite) r_byte <= '0;
         else if (tx_pronto)             r_byte <= r_byte + 3'd1;

         // Result registers load on entry so they are valid during the strobe.
         if ((w_prox == c_st_armazena) && (r_estado != c_st_armazena)) begin
            r_canal <= r_idx;
            if (r_estado == c_st_espera_echo) begin
               r_medida  <= para_bcd(999);
               r_timeout <= 1'b1;
            end else begin
               r_medida  <= w_bcd;
               r_timeout <= w_sat;
            end
         end
      end
   end

   assign medida    = r_medida;
   assign canal     = r_canal;
   assign timeout   = r_timeout;
   assign db_estado = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_sonar_multicanal.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sonar_multicanal : scoreboard bench for sonar_multicanal          |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
module tb_sonar_multicanal;
   localparam int c_n = 2;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic medir = 1'b0;
   logic modo  = 1'b0;
   logic parar = 1'b0;
   logic tx_pronto = 1'b1;
   wire  [c_n-1:0] echo;
   logic [c_n-1:0] trigger;
   logic [7:0]  tx_dado;
   logic        tx_valido;
   logic [11:0] medida;
   logic [2:0]  canal;
   logic        medida_valida, timeout, pronto;
   logic [3:0]  db_estado;

   int n_checks = 0, n_errors = 0;
   int ciclo = 0, n_bytes = 0, n_pronto = 0, n_trig1 = 0, t_fall1 = 0, t_mv1 = 0;
   int largura[c_n];
   int run[c_n];
   logic eco0_na_valida = 1'b0;
   logic prev_val = 1'b0, prev_pr = 1'b1;
   logic [7:0] prev_dado = 8'h00;
   logic [c_n-1:0] prev_trig = '0;

   logic [7:0]  q_bytes[$];
   logic [11:0] q_med[$];
   logic [2:0]  q_can[$];
   logic        q_tmo[$];

   always #5 clock = ~clock;

   sonar_multicanal #(
      .N_CANAIS(c_n), .TICKS_TRIGGER(4), .TICKS_CM(10), .MAX_CM(50),
      .ESPERA_MAX(200), .TICKS_PERIODO(3000)
   ) dut (
      .clock(clock), .reset(reset), .medir(medir), .modo(modo), .parar(parar),
      .echo(echo), .trigger(trigger), .tx_dado(tx_dado), .tx_valido(tx_valido),
      .tx_pronto(tx_pronto), .medida(medida), .canal(canal),
      .medida_valida(medida_valida), .timeout(timeout), .pronto(pronto),
      .db_estado(db_estado)
   );

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] bcd3(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // Sensor echo of w cycles: result w/10 cm, capped at 50; w = 0 means no echo.
   task automatic push_frame(input int ch, input int w);
      logic [11:0] m;
      logic t;
      int cm;
      if (w == 0) begin
         m = 12'h999;
         t = 1'b1;
      end else begin
         cm = w / 10;
         t  = (cm >= 50);
         if (t) cm = 50;
         m = bcd3(cm);
      end
      q_med.push_back(m);
      q_can.push_back(3'(ch));
      q_tmo.push_back(t);
      q_bytes.push_back(8'(8'h30 + ch));
      q_bytes.push_back(8'h2C);
      q_bytes.push_back(8'h30 + {4'h0, m[11:8]});
      q_bytes.push_back(8'h30 + {4'h0, m[7:4]});
      q_bytes.push_back(8'h30 + {4'h0, m[3:0]});
      q_bytes.push_back(t ? 8'h21 : 8'h23);
   endtask

   task automatic start_scan(input logic m, input int w0, input int w1);
      largura[0] = w0;
      largura[1] = w1;
      push_frame(0, w0);
      push_frame(1, w1);
      modo = m;
      @(posedge clock); #1 medir = 1'b1;
      @(posedge clock); #1 medir = 1'b0;
   endtask

   task automatic wait_fim();
      int t = 0;
      while (db_estado != 4'hF && t < 20000) begin
         @(negedge clock);
         t++;
      end
      check_value("estado_fim", db_estado, 4'hF);
      @(negedge clock);
      check_value("estado_inicial", db_estado, 4'h0);
   endtask

   task automatic check_reset_outputs();
      check_value("rst_trigger", trigger, 0);
      check_value("rst_tx_valido", tx_valido, 0);
      check_value("rst_tx_dado", tx_dado, 0);
      check_value("rst_medida", medida, 0);
      check_value("rst_canal", canal, 0);
      check_value("rst_medida_valida", medida_valida, 0);
      check_value("rst_timeout", timeout, 0);
      check_value("rst_pronto", pronto, 0);
      check_value("rst_estado", db_estado, 0);
   endtask

   for (genvar g = 0; g < c_n; g++) begin : g_sensor
      logic r_eco = 1'b0;
      assign echo[g] = r_eco;
      initial begin
         wait (reset === 1'b1);
         forever begin
            @(negedge trigger[g]);
            if (largura[g] > 0) begin
               repeat (20) @(negedge clock);
               r_eco = 1'b1;
               repeat (largura[g]) @(negedge clock);
               r_eco = 1'b0;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clock);
         ciclo++;
         if (reset) begin
            if (tx_valido) check_value("tx_valido_fora", db_estado, 4'h6);
            if (tx_valido && tx_pronto) begin
               n_bytes++;
               if (q_bytes.size() == 0) check_value("byte_extra", 32'(q_bytes.size()), 1);
               else                     check_value("tx_dado", tx_dado, q_bytes.pop_front());
            end
            if (prev_val && !prev_pr && tx_valido) check_value("tx_dado_estavel", tx_dado, prev_dado);
            if (medida_valida) begin
               if (q_med.size() == 0) begin
                  check_value("medida_extra", 32'(q_med.size()), 1);
               end else begin
                  check_value("medida", medida, q_med.pop_front());
                  check_value("canal", canal, q_can.pop_front());
                  check_value("timeout", timeout, q_tmo.pop_front());
               end
               if (canal == 3'd0) eco0_na_valida = echo[0];
               if (canal == 3'd1) t_mv1 = ciclo;
            end
            if (pronto) n_pronto++;
            if (trigger != '0) check_value("trigger_onehot", $countones(trigger), 1);
            for (int i = 0; i < c_n; i++) begin
               if (trigger[i]) begin
                  run[i]++;
               end else if (prev_trig[i]) begin
                  check_value("largura_trigger", run[i], 4);
                  run[i] = 0;
                  if (i == 1) t_fall1 = ciclo;
               end
            end
            if (trigger[1] && !prev_trig[1]) n_trig1++;
         end
         prev_val  = tx_valido;
         prev_pr   = tx_pronto;
         prev_dado = tx_dado;
         prev_trig = trigger;
      end
   end

   initial begin
      int p0, b0, tr1, t;
      largura[0] = 0;
      largura[1] = 0;
      repeat (3) @(negedge clock);
      check_reset_outputs();
      @(posedge clock); #1 reset = 1'b1;

      // Single scan, two normal echoes
      p0 = n_pronto;
      start_scan(1'b0, 235, 120);
      wait_fim();
      check_value("pronto_unico", n_pronto - p0, 1);

      // Channel 1 never answers
      start_scan(1'b0, 80, 0);
      wait_fim();
      check_value("atraso_timeout", ((t_mv1 - t_fall1) >= 195) && ((t_mv1 - t_fall1) <= 205), 1);

      // Channel 0 saturates while its echo is still high
      start_scan(1'b0, 1000, 77);
      wait_fim();
      check_value("sat_antes_queda", eco0_na_valida, 1);
      repeat (600) @(negedge clock);

      // Transmitter stall mid-frame
      b0 = n_bytes;
      start_scan(1'b0, 235, 120);
      t = 0;
      while (n_bytes < b0 + 8 && t < 5000) begin
         @(posedge clock);
         t++;
      end
      check_value("stall_alcancado", n_bytes >= b0 + 8, 1);
      #1 tx_pronto = 1'b0;
      repeat (7) @(posedge clock);
      #1 tx_pronto = 1'b1;
      wait_fim();
      check_value("bytes_stall", n_bytes - b0, 12);

      // Continuous mode stopped during the second scan's channel-0 frame
      p0 = n_pronto;
      b0 = n_bytes;
      start_scan(1'b1, 60, 90);
      push_frame(0, 60);
      t = 0;
      while (n_bytes < b0 + 13 && t < 20000) begin
         @(posedge clock);
         t++;
      end
      check_value("scan2_alcancado", n_bytes >= b0 + 13, 1);
      #1 parar = 1'b1;
      tr1 = n_trig1;
      wait_fim();
      @(posedge clock); #1 parar = 1'b0;
      modo = 1'b0;
      check_value("sem_trigger1", n_trig1 - tr1, 0);
      check_value("pronto_continuo", n_pronto - p0, 1);
      check_value("bytes_continuo", n_bytes - b0, 18);

      // Reset in the middle of channel 1's frame
      start_scan(1'b0, 55, 66);
      t = 0;
      while (!(tx_valido && canal == 3'd1) && t < 5000) begin
         @(posedge clock); #1;
         t++;
      end
      check_value("tx_canal1_alcancado", tx_valido && (canal == 3'd1), 1);
      reset = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check_reset_outputs();
      q_bytes.delete();
      q_med.delete();
      q_can.delete();
      q_tmo.delete();
      @(posedge clock); #1 reset = 1'b1;
      b0 = n_bytes;
      start_scan(1'b0, 44, 33);
      wait_fim();
      check_value("bytes_pos_reset", n_bytes - b0, 12);

      check_value("fila_bytes_vazia", q_bytes.size(), 0);
      check_value("fila_medidas_vazia", q_med.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sonar_multicanal.md
SONAR_MULTICANAL -- requirements
Module: sonar_multicanal

Interface
REQ-001 Parameters SHALL be:
- N_CANAIS, default 4: number of ultrasonic sensors, range 1..8.
- TICKS_TRIGGER, default 500: trigger pulse width in clock cycles.
- TICKS_CM, default 2941: clock cycles per centimetre of echo.
- MAX_CM, default 400: measurement ceiling in cm, at most 999.
- ESPERA_MAX, default 1500000: cycles to wait for an echo rise.
- TICKS_PERIODO, default 50000000: cycles between scan starts in continuous mode.
REQ-002 Ports SHALL be:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- medir  in  1  start-scan pulse.
- modo  in  1  0 = single scan, 1 = continuous scans.
- parar  in  1  stop request.
- echo  in  N_CANAIS  asynchronous sensor echoes.
- trigger  out  N_CANAIS  sensor trigger pulses.
- tx_dado  out  8  ASCII byte to the serial transmitter.
- tx_valido  out  1  byte-valid strobe.
- tx_pronto  in  1  transmitter ready.
- medida  out  12  last result, 3-digit BCD.
- canal  out  3  channel of the last result.
- medida_valida  out  1  one-cycle result strobe.
- timeout  out  1  last result was a timeout.
- pronto  out  1  one-cycle scan-complete pulse.
- db_estado  out  4  FSM state code.

Function
REQ-003 Each echo bit SHALL pass through a 2-flop synchroniser; an echo rise is detected 2-3 cycles after the pin edge.
REQ-004 FSM states and codes SHALL be: INICIAL 0, PREPARA 1, GERA_TRIGGER 2, ESPERA_ECHO 3, MEDE 4, ARMAZENA 5, TRANSMITE 6, PROX_CANAL 7, ESPERA_PERIODO 8, FIM F.
REQ-005 INICIAL SHALL go to PREPARA on medir=1, which zeroes the channel index and counters; medir in any other state SHALL be ignored.
REQ-006 GERA_TRIGGER SHALL drive trigger[idx]=1 for exactly TICKS_TRIGGER cycles, with all other trigger bits 0.
REQ-007 ESPERA_ECHO SHALL wait for a synchronised rise on echo[idx]; an echo already high on entry SHALL NOT count as a rise.
REQ-008 If no rise occurs within ESPERA_MAX cycles, the FSM SHALL go to ARMAZENA with result 999 BCD and timeout=1.
REQ-009 MEDE SHALL increment the BCD result once per TICKS_CM cycles while echo is high, and SHALL go to ARMAZENA on the echo fall.
REQ-010 When the result reaches MAX_CM, MEDE SHALL saturate at MAX_CM, set timeout=1 and go to ARMAZENA without waiting for the echo fall.
REQ-011 ARMAZENA SHALL update medida, canal and timeout and pulse medida_valida for one cycle.
REQ-012 TRANSMITE SHALL send 6 bytes in order:
- ASCII channel digit.
- ','
- hundreds, tens and units digits in ASCII ('0'+digit).
- '#' when timeout=0, '!' when timeout=1.
REQ-013 Transmit handshake: a byte transfers on a cycle with tx_valido=1 and tx_pronto=1; tx_dado SHALL hold stable while tx_valido=1 and tx_pronto=0; tx_valido SHALL be 0 outside TRANSMITE.
REQ-014 PROX_CANAL SHALL increment the channel index and return to GERA_TRIGGER while idx < N_CANAIS-1; otherwise it SHALL pulse pronto and go to ESPERA_PERIODO when modo=1, or to FIM when modo=0.
REQ-015 ESPERA_PERIODO SHALL restart at channel 0 when TICKS_PERIODO cycles have elapsed since the scan start; if the scan was longer than the period, it SHALL restart on the next cycle.
REQ-016 parar=1 SHALL be sampled only in PROX_CANAL and ESPERA_PERIODO and SHALL lead to FIM; an in-flight measurement and frame always complete.
REQ-017 FIM SHALL go to INICIAL on the next cycle.
REQ-018 When parar and the last-channel condition coincide in PROX_CANAL, pronto SHALL pulse and the FSM SHALL go to FIM.

Reset
REQ-019 On a clock edge with reset=0, all of the following SHALL reach these values on that edge, from any state including mid-trigger or mid-frame:
- state INICIAL.
- trigger, tx_valido, medida_valida, pronto, timeout = 0.
- medida = 000; canal = 0; tx_dado = 00.
- all counters and synchronisers cleared.

Structure
REQ-020 Package sonar_pkg SHALL hold the state encoding, the ASCII constants (',', '#', '!', '0') and the frame length of 6.
REQ-021 Sub-module contador_cm_bcd SHALL contain the TICKS_CM prescaler and the 3-digit BCD counter with clear, enable and saturation at a BCD limit.

Verification
REQ-022 Benches SHALL use TICKS_TRIGGER=4, TICKS_CM=10, MAX_CM=50, ESPERA_MAX=200, TICKS_PERIODO=3000, N_CANAIS=2, and SHALL cover:
- Single scan, modo=0: echo0 high 235 cycles, echo1 high 120 cycles -> frames "0,023#" and "1,012#", one pronto pulse, FSM returns to INICIAL.
- Echo1 never rises -> medida=999, timeout=1, frame "1,999!" about 200 cycles after the trigger ends.
- Echo0 held high 1000 cycles -> medida=050, frame "0,050!", FSM leaves MEDE at 50 cm.
- tx_pronto low for 7 cycles mid-frame -> tx_dado stable during the stall, no byte lost or duplicated.
- modo=1 with parar asserted during the second scan's channel-0 transmit -> channel-0 frame completes, FSM reaches FIM then INICIAL, no trigger[1] pulse.
- reset=0 during TRANSMITE -> all outputs at reset values on the next edge; medir afterwards starts a clean scan at channel 0.
